uart_tx_fifo_param: RTL and testbench

Parametrised UART transmitter with an internal baud divider and an input FIFO. Data width, stop-bit count and FIFO depth are parameters; parity is selected at run time. Words enter through a valid/ready handshake. Queued words go out as contiguous frames with no idle gap between them. It sits between a host-side byte producer and the serial pad, and is the generalised successor of the fixed 8-bit, externally-ticked transmitter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx_fifo_param.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: state encoding,
// parity helper and parameter legality checks.
package uart_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Data is zero-extended to 16 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [15:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

  function automatic bit stop_bits_legal(input int n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit data_w_legal(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous input FIFO for the UART transmitter. Push is ignored when full
// and pop is ignored when empty, so neither can corrupt stored data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: input FIFO, baud counter, shift register and
// a frame FSM that chains queued words into contiguous frames.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | STOP_BITS stop bits (high); may pop straight into START
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("uart_tx_fifo_param: DATA_W must be in 5..9");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               tx_q, tx_d;
  logic               baud_last;
  logic               pop;

  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_full;
  logic               fifo_empty;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != ST_IDLE);
  assign tx        = tx_q;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == DATA_LAST) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d = '0;
            // Back-to-back: the next start bit follows the last stop cycle.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        idx_d   = '0;
      end
    endcase

    // Parity mode is captured with the word so mid-frame changes are ignored.
    if (pop) begin
      shift_d   = fifo_data;
      par_en_d  = parity_en;
      par_bit_d = parity_bit(16'(fifo_data), parity_odd);
      baud_d    = '0;
      idx_d     = '0;
    end

    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: an 8-bit/1-stop instance and a
// 7-bit/2-stop instance, both at 4 clocks per bit.
module tb_uart_tx_fifo_param;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_valid_a, in_ready_a, parity_en_a, parity_odd_a, tx_a, busy_a;
  logic [7:0] in_data_a;
  logic [2:0] fifo_count_a;

  logic       in_valid_b, in_ready_b, parity_en_b, parity_odd_b, tx_b, busy_b;
  logic [6:0] in_data_b;
  logic [2:0] fifo_count_b;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .parity_en(parity_en_a), .parity_odd(parity_odd_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );

  uart_tx_fifo_param #(
    .DATA_W(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .parity_en(parity_en_b), .parity_odd(parity_odd_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  // Capture tx/busy of both instances on the falling edge while cap_en is set.
  logic cap_en = 1'b0;
  int   cap_idx = 0;
  int   falls_a = 0;
  int   falls_b = 0;
  logic busy_prev_a = 1'b0;
  logic busy_prev_b = 1'b0;
  logic obs_a [0:1023];
  logic bobs_a [0:1023];
  logic obs_b [0:1023];
  logic bobs_b [0:1023];

  always @(negedge clk) begin
    if (!cap_en) begin
      cap_idx = 0;
      falls_a = 0;
      falls_b = 0;
    end else if (cap_idx < 1024) begin
      obs_a[cap_idx]  = tx_a;
      bobs_a[cap_idx] = busy_a;
      obs_b[cap_idx]  = tx_b;
      bobs_b[cap_idx] = busy_b;
      if (busy_prev_a && !busy_a) falls_a++;
      if (busy_prev_b && !busy_b) falls_b++;
      cap_idx++;
    end
    busy_prev_a = busy_a;
    busy_prev_b = busy_b;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    in_valid_a = 1'b1;
    in_data_a  = d;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [6:0] d);
    in_valid_b = 1'b1;
    in_data_b  = d;
    tick();
    in_valid_b = 1'b0;
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 2000 && cap_idx < n; i++) tick();
    if (cap_idx < n) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: got %0d samples, required %0d", cap_idx, n);
    end
  endtask

  task automatic stop_cap();
    cap_en = 1'b0;
    tick();
  endtask

  // Time-ordered bit pattern (bit 0 = start bit) expanded to one bit per clock.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < nbits * CPB; c++) v[c] = bits[c / CPB];
    return v;
  endfunction

  function automatic logic [63:0] ones(input int len);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < len; c++) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] win(input bit inst_b, input bit of_busy, input int base, input int len);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < len; c++) begin
      if (inst_b) v[c] = of_busy ? bobs_b[base + c] : obs_b[base + c];
      else        v[c] = of_busy ? bobs_a[base + c] : obs_a[base + c];
    end
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; parity_en_a = 1'b0; parity_odd_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; parity_en_b = 1'b0; parity_odd_b = 1'b0;
    tick();
    tick();
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a: got %b expected 1", in_ready_a); end
    checks++; if (fifo_count_a !== 3'd0) begin errors++; $display("FAIL reset_count_a: got %0d expected 0", fifo_count_a); end
    checks++; if ({tx_b, busy_b, in_ready_b, fifo_count_b} !== 6'b101000) begin
      errors++; $display("FAIL reset_b: got %b expected 101000", {tx_b, busy_b, in_ready_b, fifo_count_b});
    end
    #3 reset = 1'b0;
    tick();
    tick();
    checks++; if ({tx_a, busy_a} !== 2'b10) begin errors++; $display("FAIL idle_after_reset: got %b expected 10", {tx_a, busy_a}); end
  endtask

  // One frame on instance A; pattern is time-ordered starting with the start bit.
  task automatic run_frame_a(input string name, input logic [7:0] d, input logic pe,
                             input logic po, input logic [15:0] pat, input int nbits);
    logic [63:0] got;
    logic [63:0] want;
    int len;
    len = nbits * CPB;
    parity_en_a  = pe;
    parity_odd_a = po;
    push_a(d);
    cap_en = 1'b1;
    wait_cap(len + 3);
    got  = win(1'b0, 1'b0, 1, len);
    want = expand(pat, nbits);
    checks++; if (got !== want) begin errors++; $display("FAIL %s_tx: got %h expected %h", name, got, want); end
    got = win(1'b0, 1'b1, 1, len);
    checks++; if (got !== ones(len)) begin errors++; $display("FAIL %s_busy: got %h expected %h", name, got, ones(len)); end
    checks++; if ({bobs_a[0], bobs_a[len + 1], obs_a[len + 1]} !== 3'b001) begin
      errors++; $display("FAIL %s_edges: got %b expected 001", name, {bobs_a[0], bobs_a[len + 1], obs_a[len + 1]});
    end
    stop_cap();
  endtask

  task automatic test_parity_even();
    run_frame_a("even_a5", 8'hA5, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
  endtask

  task automatic test_parity_odd();
    run_frame_a("odd_a5", 8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11);
  endtask

  task automatic test_no_parity();
    run_frame_a("nopar_00", 8'h00, 1'b0, 1'b0, {1'b1, 8'h00, 1'b0}, 10);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w [5];
    logic [15:0] pat [5];
    logic [63:0] got;
    logic [63:0] want;
    int k;
    int nlow;
    logic acc;
    w[0] = 8'h01; w[1] = 8'h03; w[2] = 8'h07; w[3] = 8'h80; w[4] = 8'hFE;
    pat[0] = {1'b1, 1'b1, 8'h01, 1'b0};
    pat[1] = {1'b1, 1'b0, 8'h03, 1'b0};
    pat[2] = {1'b1, 1'b1, 8'h07, 1'b0};
    pat[3] = {1'b1, 1'b1, 8'h80, 1'b0};
    pat[4] = {1'b1, 1'b1, 8'hFE, 1'b0};
    parity_en_a = 1'b1;
    parity_odd_a = 1'b0;
    in_valid_a = 1'b1;
    in_data_a = w[0];
    tick();
    cap_en = 1'b1;
    k = 1;
    in_data_a = w[1];
    for (int i = 0; i < 50 && k < 5; i++) begin
      acc = in_ready_a;
      tick();
      if (acc) begin
        k++;
        if (k < 5) in_data_a = w[k];
      end
    end
    checks++; if (k != 5) begin errors++; $display("FAIL b2b_accepted: got %0d expected 5", k); end
    checks++; if ({fifo_count_a, in_ready_a} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL b2b_full: got count %0d ready %b expected count 4 ready 0", fifo_count_a, in_ready_a);
    end
    // Offer a word while full; it must not be queued.
    in_data_a = 8'hFF;
    tick();
    tick();
    in_valid_a = 1'b0;
    checks++; if (fifo_count_a !== 3'd4) begin errors++; $display("FAIL b2b_full_hold: got %0d expected 4", fifo_count_a); end
    wait_cap(1 + 5 * 44 + 3);
    for (int f = 0; f < 5; f++) begin
      got  = win(1'b0, 1'b0, 1 + 44 * f, 44);
      want = expand(pat[f], 11);
      checks++; if (got !== want) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", f, got, want); end
    end
    nlow = 0;
    for (int c = 1; c <= 220; c++) if (bobs_a[c] !== 1'b1) nlow++;
    checks++; if (nlow != 0) begin errors++; $display("FAIL b2b_busy_gap: got %0d low cycles expected 0", nlow); end
    checks++; if ({bobs_a[221], obs_a[221]} !== 2'b01) begin
      errors++; $display("FAIL b2b_end: got busy/tx %b expected 01", {bobs_a[221], obs_a[221]});
    end
    checks++; if (falls_a != 1) begin errors++; $display("FAIL b2b_busy_falls: got %0d expected 1", falls_a); end
    checks++; if ({fifo_count_a, in_ready_a} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL b2b_drained: got count %0d ready %b expected count 0 ready 1", fifo_count_a, in_ready_a);
    end
    stop_cap();
  endtask

  task automatic test_mode_toggle();
    logic [63:0] got;
    logic [63:0] want;
    parity_en_a = 1'b1;
    parity_odd_a = 1'b0;
    push_a(8'hA5);
    cap_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    parity_odd_a = 1'b1;
    push_a(8'hA5);
    wait_cap(1 + 88 + 3);
    got  = win(1'b0, 1'b0, 1, 44);
    want = expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    checks++; if (got !== want) begin errors++; $display("FAIL toggle_frame1: got %h expected %h", got, want); end
    got  = win(1'b0, 1'b0, 45, 44);
    want = expand({1'b1, 1'b1, 8'hA5, 1'b0}, 11);
    checks++; if (got !== want) begin errors++; $display("FAIL toggle_frame2: got %h expected %h", got, want); end
    checks++; if (falls_a != 1) begin errors++; $display("FAIL toggle_busy_falls: got %0d expected 1", falls_a); end
    stop_cap();
    parity_odd_a = 1'b0;
  endtask

  task automatic test_stop2();
    logic [63:0] got;
    logic [63:0] want;
    parity_en_b = 1'b0;
    parity_odd_b = 1'b0;
    push_b(7'h7F);
    cap_en = 1'b1;
    wait_cap(40 + 3);
    got  = win(1'b1, 1'b0, 1, 40);
    want = expand({2'b11, 7'h7F, 1'b0}, 10);
    checks++; if (got !== want) begin errors++; $display("FAIL stop2_tx: got %h expected %h", got, want); end
    got = win(1'b1, 1'b1, 1, 40);
    checks++; if (got !== ones(40)) begin errors++; $display("FAIL stop2_busy: got %h expected %h", got, ones(40)); end
    checks++; if (bobs_b[41] !== 1'b0) begin errors++; $display("FAIL stop2_len: got busy %b at cycle 41 expected 0", bobs_b[41]); end
    stop_cap();
    parity_en_b = 1'b1;
    push_b(7'h2A);
    cap_en = 1'b1;
    wait_cap(44 + 3);
    got  = win(1'b1, 1'b0, 1, 44);
    want = expand({2'b11, 1'b1, 7'h2A, 1'b0}, 11);
    checks++; if (got !== want) begin errors++; $display("FAIL stop2_parity_tx: got %h expected %h", got, want); end
    checks++; if ({bobs_b[44], bobs_b[45]} !== 2'b10) begin
      errors++; $display("FAIL stop2_parity_len: got %b expected 10", {bobs_b[44], bobs_b[45]});
    end
    stop_cap();
  endtask

  task automatic test_reset_mid_frame();
    parity_en_a = 1'b0;
    parity_odd_a = 1'b0;
    push_a(8'h00);
    push_a(8'h00);
    push_a(8'h00);
    // 16 more edges puts the line inside data bit 3 of the first frame.
    for (int i = 0; i < 16; i++) tick();
    checks++; if ({tx_a, busy_a, fifo_count_a} !== {1'b0, 1'b1, 3'd2}) begin
      errors++; $display("FAIL midreset_pre: got tx %b busy %b count %0d expected tx 0 busy 1 count 2", tx_a, busy_a, fifo_count_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if ({tx_a, busy_a, in_ready_a, fifo_count_a} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      errors++; $display("FAIL midreset_async: got tx %b busy %b ready %b count %0d expected tx 1 busy 0 ready 1 count 0",
                         tx_a, busy_a, in_ready_a, fifo_count_a);
    end
    #3 reset = 1'b0;
    tick();
    tick();
    tick();
    checks++; if ({tx_a, busy_a} !== 2'b10) begin errors++; $display("FAIL midreset_idle: got %b expected 10", {tx_a, busy_a}); end
    run_frame_a("after_reset_5a", 8'h5A, 1'b1, 1'b0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11);
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_back_to_back();
    test_mode_toggle();
    test_stop2();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
